// File: rtl/rv32_pkg.sv
// Shared types for the RV32 memory-side blocks.
package rv32_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/wdog_counter.sv
// Bus-timeout watchdog: counts enabled cycles and flags the last permitted one.
module wdog_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  // TIMEOUT of 0 leaves the counter free-running but never expiring.
  assign expired = (TIMEOUT != 0) && en && (cnt == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data to single memory bus arbiter; data has fixed priority,
// one transaction in flight, all bus and requester outputs registered.
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_sel,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);
  arb_state_t state;
  arb_owner_t owner;
  logic       serving;
  logic       expired;

  assign serving = (state == SERVE_I) || (state == SERVE_D);

  wdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .nRst    (nRst),
    .en      (serving),
    .clr     (!serving),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel   <= d_sel;
            mem_req   <= 1'b1;
            owner     <= OWN_D;
            busy      <= 1'b1;
            state     <= SERVE_D;
          end else if (i_req) begin
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            mem_sel  <= 4'hF;
            mem_req  <= 1'b1;
            owner    <= OWN_I;
            busy     <= 1'b1;
            state    <= SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          // A completing ack beats an expiry landing in the same cycle.
          if (mem_ack || expired) begin
            mem_req <= 1'b0;
            err     <= !mem_ack;
            state   <= RESP;
            if (owner == OWN_D) begin
              d_ack   <= 1'b1;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
